// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives pc to a combinational instruction memory and buffers
// {pc, instr} pairs in a 2-entry queue handed to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        align_fault,
  output logic        busy
);

  localparam logic [31:0] PcMask = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] q_pc_q    [2];
  logic [31:0] q_instr_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic        fault_q;

  logic redirect_fire, redirect_bad, enq, deq;

  always_comb begin
    redirect_fire = (state_q == StRun) && redirect_valid;
    redirect_bad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= 32'(MEM_BYTES));
    // Enqueue looks at the registered count, so a dequeue at full cannot free a slot this cycle.
    enq = (state_q == StRun) && fetch_en && (count_q < 2'd2) && !redirect_valid;
    deq = out_valid && out_ready && !redirect_fire;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun:  if (redirect_fire && redirect_bad) state_d = StHalt;
      StHalt: state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StInit;
      pc_q     <= RESET_PC;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      fault_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (redirect_fire) begin
        // Flush wins over both queue ports; a bad target keeps the old pc.
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= 2'd0;
        if (redirect_bad) fault_q <= 1'b1;
        else              pc_q    <= redirect_pc;
      end else begin
        if (enq) begin
          q_pc_q[wr_ptr_q]    <= pc_q;
          q_instr_q[wr_ptr_q] <= instr_in;
          wr_ptr_q            <= ~wr_ptr_q;
          pc_q                <= (pc_q + 32'd4) & PcMask;
        end
        if (deq) rd_ptr_q <= ~rd_ptr_q;
        unique case ({enq, deq})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    pc          = pc_q;
    out_valid   = (count_q != 2'd0);
    out_pc      = out_valid ? q_pc_q[rd_ptr_q]    : '0;
    out_instr   = out_valid ? q_instr_q[rd_ptr_q] : '0;
    align_fault = fault_q;
    busy        = (state_q == StRun);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned MemBytes = 32;
  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [98:0] RstVec   = {ResetPc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        align_fault;
  logic        busy;

  logic [31:0] mem [8];
  assign instr_in = mem[pc[4:2]];

  fetch_unit #(.MEM_BYTES(MemBytes), .RESET_PC(ResetPc)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc), .instr_in(instr_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .align_fault(align_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [98:0] dut_vec;
  assign dut_vec = {pc, out_valid, out_pc, out_instr, align_fault, busy};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = init, 1 = run, 2 = halted; queue holds {pc, instr}.
  int          m_phase;
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic        m_fault;

  function automatic logic [98:0] exp_vec();
    logic [31:0] hp, hi;
    hp = '0;
    hi = '0;
    if (m_q.size() > 0) begin
      hp = m_q[0][63:32];
      hi = m_q[0][31:0];
    end
    return {m_pc, (m_q.size() > 0), hp, hi, m_fault, (m_phase == 1)};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pc    = ResetPc;
    m_q.delete();
    m_fault = 1'b0;
  endtask

  task automatic model_step();
    bit do_enq, do_deq;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (redirect_valid) begin
        m_q.delete();
        if (redirect_pc[1:0] != 2'b00 || redirect_pc >= 32'(MemBytes)) begin
          m_fault = 1'b1;
          m_phase = 2;
        end else begin
          m_pc = redirect_pc;
        end
      end else begin
        do_enq = fetch_en && (m_q.size() < 2);
        do_deq = (m_q.size() > 0) && out_ready;
        if (do_deq) void'(m_q.pop_front());
        if (do_enq) begin
          m_q.push_back({m_pc, mem[m_pc[4:2]]});
          m_pc = (m_pc + 32'd4) % 32'(MemBytes);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec !== RstVec) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_vec, RstVec);
    end
  endtask

  task automatic test_startup();
    fetch_en = 1'b1; out_ready = 1'b1;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL init_cycle: got busy/valid %b expected 10", {busy, out_valid});
    end
    tick();
    n_checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd0, 32'h0094_0333}) begin
      n_fail++;
      $display("FAIL first_word: got %b %h %h expected 1 0 00940333", out_valid, out_pc, out_instr);
    end
    tick();
    n_checks++;
    if ({out_pc, out_instr} !== {32'd4, 32'h4139_03b3}) begin
      n_fail++;
      $display("FAIL second_word: got %h %h expected 4 413903b3", out_pc, out_instr);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL startup_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int accepted;
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL bp_fill c%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if ({pc, out_valid, out_pc} !== {32'd8, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL bp_hold: got pc %h valid %b head %h expected 8 1 0", pc, out_valid, out_pc);
    end
    out_ready = 1'b1;
    exp_pc = 32'd0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        n_checks++;
        if (out_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL bp_stream #%0d: got %h expected %h", accepted, out_pc, exp_pc);
        end
        exp_pc = (exp_pc + 32'd4) % 32'(MemBytes);
        accepted++;
      end
      tick();
    end
    n_checks++;
    if (accepted < 9) begin
      n_fail++;
      $display("FAIL bp_throughput: got %0d accepted expected >= 9", accepted);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int wraps;
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    exp_pc = 32'd0;
    wraps = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid) begin
        n_checks++;
        if (out_pc !== exp_pc || out_instr !== mem[exp_pc[4:2]]) begin
          n_fail++;
          $display("FAIL wrap_seq: got %h/%h expected %h/%h", out_pc, out_instr, exp_pc,
                   mem[exp_pc[4:2]]);
        end
        if (exp_pc == 32'd28) wraps++;
        exp_pc = (exp_pc + 32'd4) % 32'(MemBytes);
      end
    end
    n_checks++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL wrap_seen: got %0d passes through 28 expected 1", wraps);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({out_valid, pc} !== {1'b0, 32'd16}) begin
      n_fail++;
      $display("FAIL redir_flush: got valid %b pc %h expected 0 10", out_valid, pc);
    end
    tick();
    n_checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd16, mem[4]}) begin
      n_fail++;
      $display("FAIL redir_target: got %b %h %h expected 1 10 %h", out_valid, out_pc, out_instr,
               mem[4]);
    end
    out_ready = 1'b1;
    exp_pc = 32'd16;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        n_checks++;
        if (out_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL redir_no_stale: got %h expected %h", out_pc, exp_pc);
        end
        exp_pc = (exp_pc + 32'd4) % 32'(MemBytes);
      end
      tick();
    end
  endtask

  task automatic test_fault();
    logic [31:0] targets [2];
    logic [31:0] old_pc;
    targets[0] = 32'h0000_0006;
    targets[1] = 32'h0000_0040;
    for (int t = 0; t < 2; t++) begin
      apply_reset();
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      old_pc = pc;
      redirect_valid = 1'b1; redirect_pc = targets[t];
      tick();
      n_checks++;
      if ({align_fault, busy, out_valid, pc} !== {3'b100, old_pc}) begin
        n_fail++;
        $display("FAIL fault_%h: got f/b/v %b pc %h expected 100 %h", targets[t],
                 {align_fault, busy, out_valid}, pc, old_pc);
      end
      redirect_pc = 32'd16;
      for (int i = 0; i < 3; i++) tick();
      redirect_valid = 1'b0;
      n_checks++;
      if ({align_fault, busy, out_valid, pc} !== {3'b100, old_pc}) begin
        n_fail++;
        $display("FAIL fault_sticky_%h: got f/b/v %b pc %h expected 100 %h", targets[t],
                 {align_fault, busy, out_valid}, pc, old_pc);
      end
    end
    apply_reset();
    n_checks++;
    if (align_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_cleared: got %b expected 0", align_fault);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== RstVec) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", dut_vec, RstVec);
    end
    model_reset();
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_pc} !== {1'b1, ResetPc}) begin
      n_fail++;
      $display("FAIL restart_pc: got %b %h expected 1 %h", out_valid, out_pc, ResetPc);
    end
  endtask

  task automatic test_random();
    int halted;
    apply_reset();
    halted = 0;
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 4) < 3);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (m_phase == 2) halted++;
      if (halted > 4) begin
        redirect_valid = 1'b0;
        apply_reset();
        halted = 0;
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    mem[0] = 32'h0094_0333;
    mem[1] = 32'h4139_03b3;
    test_reset();
    test_startup();
    test_backpressure();
    test_wrap();
    test_redirect();
    test_fault();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
